// File: rtl/edc_pkg.sv
// Shared definitions for EDC input-conditioning stages: FSM state
// encoding and default debounce constants.
package edc_pkg;

  localparam logic [1:0] STABLE_LOW  = 2'd0;
  localparam logic [1:0] PEND_HIGH   = 2'd1;
  localparam logic [1:0] STABLE_HIGH = 2'd2;
  localparam logic [1:0] PEND_LOW    = 2'd3;

  typedef enum logic [1:0] {
    ST_STABLE_LOW  = STABLE_LOW,
    ST_PEND_HIGH   = PEND_HIGH,
    ST_STABLE_HIGH = STABLE_HIGH,
    ST_PEND_LOW    = PEND_LOW
  } state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_CNT_WIDTH       = 5;
  localparam bit DEF_INIT_LEVEL      = 1'b0;

endpackage

// File: rtl/sync_chain.sv
// Plain flop-chain synchronizer for an asynchronous level; no logic between
// stages so the chain can be constrained as a metastability path.
module sync_chain #(
  parameter int STAGES = 2,
  parameter bit INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] flops;

  always_ff @(posedge clk) begin
    if (rst) flops <= {STAGES{INIT}};
    else     flops <= {flops[STAGES-2:0], d};
  end

  assign q = flops[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Turns a bouncy asynchronous level into a clean level on i_clk; reports
// qualification in progress (o_busy) and aborted candidates (o_glitch).
//
// state          | meaning
// ST_STABLE_LOW  | output low, synchronized input agrees
// ST_PEND_HIGH   | output low, counting consecutive high samples
// ST_STABLE_HIGH | output high, synchronized input agrees
// ST_PEND_LOW    | output high, counting consecutive low samples
module input_debouncer
  import edc_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
  parameter bit INIT_LEVEL      = DEF_INIT_LEVEL
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_data,
  output logic o_data,
  output logic o_busy,
  output logic o_glitch
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 s;
  logic                 level;
  logic                 busy;
  logic                 glitch;
  logic [CNT_WIDTH-1:0] cnt;
  state_t               state;

  sync_chain #(
    .STAGES (SYNC_STAGES),
    .INIT   (INIT_LEVEL)
  ) u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (i_data),
    .q   (s)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= INIT_LEVEL ? ST_STABLE_HIGH : ST_STABLE_LOW;
      level  <= INIT_LEVEL;
      busy   <= 1'b0;
      glitch <= 1'b0;
      cnt    <= '0;
    end else begin
      glitch <= 1'b0;
      case (state)
        ST_STABLE_LOW, ST_STABLE_HIGH: begin
          if (s != level) begin
            state <= level ? ST_PEND_LOW : ST_PEND_HIGH;
            cnt   <= CNT_WIDTH'(1);
            busy  <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        ST_PEND_HIGH, ST_PEND_LOW: begin
          if (s != level) begin
            // The sample on the completing edge is already counted, so commit
            // regardless of what the raw input does afterwards.
            if (cnt == CNT_LAST) begin
              level <= ~level;
              state <= level ? ST_STABLE_LOW : ST_STABLE_HIGH;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            state  <= level ? ST_STABLE_HIGH : ST_STABLE_LOW;
            cnt    <= '0;
            busy   <= 1'b0;
            glitch <= 1'b1;
          end
        end
        default: begin
          state <= level ? ST_STABLE_HIGH : ST_STABLE_LOW;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data   = level;
  assign o_busy   = busy;
  assign o_glitch = glitch;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: a vector table for the main build plus
// hand-written sequences for bounce trains and INIT_LEVEL=1 builds.
module tb_input_debouncer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, d0, q0, busy0, gl0;
  logic rst1, d1, q1, busy1, gl1;
  logic rst2, d2, q2, busy2, gl2;

  input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(5), .INIT_LEVEL(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst0), .i_data(d0), .o_data(q0), .o_busy(busy0), .o_glitch(gl0));
  input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(5), .INIT_LEVEL(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_data(d1), .o_data(q1), .o_busy(busy1), .o_glitch(gl1));
  input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(2), .CNT_WIDTH(5), .INIT_LEVEL(1'b1)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_data(d2), .o_data(q2), .o_busy(busy2), .o_glitch(gl2));

  typedef struct {
    logic rst;
    logic d;
    logic e_data;
    logic e_busy;
    logic e_glitch;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(input logic r, input logic d, input logic ed,
                              input logic eb, input logic eg);
    vec_t v;
    v.rst = r; v.d = d; v.e_data = ed; v.e_busy = eb; v.e_glitch = eg;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gl_cnt;
    rst0 = 1'b1; d0 = 1'b0;
    rst1 = 1'b1; d1 = 1'b1;
    rst2 = 1'b1; d2 = 1'b1;

    // reset with input high, then idle low
    add(1,1, 0,0,0); add(1,1, 0,0,0);
    add(0,0, 0,0,0); add(0,0, 0,0,0); add(0,0, 0,0,0);
    // clean rise, E0 = first vector with d=1
    add(0,1, 0,0,0); add(0,1, 0,0,0); add(0,1, 0,1,0); add(0,1, 0,1,0);
    add(0,1, 0,1,0); add(0,1, 1,0,0); add(0,1, 1,0,0);
    // clean fall
    add(0,0, 1,0,0); add(0,0, 1,0,0); add(0,0, 1,1,0); add(0,0, 1,1,0);
    add(0,0, 1,1,0); add(0,0, 0,0,0); add(0,0, 0,0,0);
    // two-cycle high glitch
    add(0,1, 0,0,0); add(0,1, 0,0,0); add(0,0, 0,1,0); add(0,0, 0,1,0);
    add(0,0, 0,0,1); add(0,0, 0,0,0); add(0,0, 0,0,0);
    // reset while cnt=2 in PEND_HIGH, then a fresh qualification
    add(0,1, 0,0,0); add(0,1, 0,0,0); add(0,1, 0,1,0); add(0,1, 0,1,0);
    add(1,1, 0,0,0);
    add(0,1, 0,0,0); add(0,1, 0,0,0); add(0,1, 0,1,0); add(0,1, 0,1,0);
    add(0,1, 0,1,0); add(0,1, 1,0,0);

    foreach (vecs[i]) begin
      rst0 = vecs[i].rst;
      d0   = vecs[i].d;
      step();
      check($sformatf("vec%0d o_data", i),   q0,    vecs[i].e_data);
      check($sformatf("vec%0d o_busy", i),   busy0, vecs[i].e_busy);
      check($sformatf("vec%0d o_glitch", i), gl0,   vecs[i].e_glitch);
    end

    // bounce train from a low level: 20 toggles then hold high
    rst0 = 1'b1; d0 = 1'b0;
    step(); step();
    rst0 = 1'b0;
    gl_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      d0 = (k >= 20) ? 1'b1 : ((k % 2) == 0);
      step();
      if (gl0 === 1'b1) gl_cnt++;
      if (k < 25) check($sformatf("bounce k%0d o_data", k), q0, 1'b0);
      if (k == 25) begin
        check("bounce commit o_data", q0, 1'b1);
        check("bounce commit o_busy", busy0, 1'b0);
      end
      if (k >= 22 && k < 25) check($sformatf("bounce k%0d o_busy", k), busy0, 1'b1);
    end
    n_cmp++;
    if (gl_cnt != 10) begin
      n_bad++;
      $display("FAIL bounce glitch count: got %0d, expected 10", gl_cnt);
    end

    // INIT_LEVEL=1 builds: reset level, then a clean fall
    step();
    check("init1 reset o_data", q1, 1'b1);
    check("init1 d2 reset o_data", q2, 1'b1);
    check("init1 reset o_busy", busy1, 1'b0);
    rst1 = 1'b0; rst2 = 1'b0;
    step(); step();
    check("init1 idle o_data", q1, 1'b1);
    d1 = 1'b0; d2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("init1 E0+%0d o_data", k), q1, (k < 5) ? 1'b1 : 1'b0);
      check($sformatf("init1 E0+%0d o_busy", k), busy1, (k >= 2 && k < 5));
      check($sformatf("dc2 E0+%0d o_data", k), q2, (k < 3) ? 1'b1 : 1'b0);
      check($sformatf("dc2 E0+%0d o_busy", k), busy2, (k == 2));
      check($sformatf("dc2 E0+%0d o_glitch", k), gl2, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
